// File: rtl/Purple_Jade_pkg.sv
// Purple_Jade_pkg: shared constants and types for the data-memory arbiter.
//   WORD_SIZE_P  - data word width (also the default address width)
//   DMEM_NUM_REQ - default number of requesters sharing the data memory
//   dmem_arb_state_e - arbiter FSM states (ARB, LOCKED)
package Purple_Jade_pkg;

   localparam int unsigned WORD_SIZE_P  = 32;
   localparam int unsigned DMEM_NUM_REQ = 2;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } dmem_arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshake bus plus memory command port of the
// data-memory arbiter.
//   req_*_i            per-requester request valid/op/lock/address/data
//   req_ready_o        per-requester grant (one-hot or zero)
//   resp_v_o/resp_data_o  one-hot read response valid and shared read data
//   flush_i            back-end mispredict, squashes requester 0
//   data_mem_*         memory command outputs and registered read data input
// Modports: slave = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if
   import Purple_Jade_pkg::*;
#(
   parameter int unsigned num_req_p    = DMEM_NUM_REQ,
   parameter int unsigned addr_width_p = WORD_SIZE_P
);

   logic [num_req_p-1:0]                    req_v_i;
   logic [num_req_p-1:0]                    req_w_i;
   logic [num_req_p-1:0]                    req_lock_i;
   logic [num_req_p-1:0][addr_width_p-1:0]  req_addr_i;
   logic [num_req_p-1:0][WORD_SIZE_P-1:0]   req_data_i;
   logic [num_req_p-1:0]                    req_ready_o;
   logic [num_req_p-1:0]                    resp_v_o;
   logic [WORD_SIZE_P-1:0]                  resp_data_o;
   logic                                    flush_i;

   logic                                    data_mem_w_v_i;
   logic [addr_width_p-1:0]                 data_mem_w_addr_i;
   logic [WORD_SIZE_P-1:0]                  data_mem_w_data_i;
   logic                                    data_mem_r_v_i;
   logic [addr_width_p-1:0]                 data_mem_r_addr_i;
   logic [WORD_SIZE_P-1:0]                  data_mem_r_data_o;

   modport slave (
      input  req_v_i, req_w_i, req_lock_i, req_addr_i, req_data_i, flush_i,
      input  data_mem_r_data_o,
      output req_ready_o, resp_v_o, resp_data_o,
      output data_mem_w_v_i, data_mem_w_addr_i, data_mem_w_data_i,
      output data_mem_r_v_i, data_mem_r_addr_i
   );

   modport master (
      output req_v_i, req_w_i, req_lock_i, req_addr_i, req_data_i, flush_i,
      output data_mem_r_data_o,
      input  req_ready_o, resp_v_o, resp_data_o,
      input  data_mem_w_v_i, data_mem_w_addr_i, data_mem_w_data_i,
      input  data_mem_r_v_i, data_mem_r_addr_i
   );

endinterface

// File: rtl/bsg_arb_round_robin.sv
// bsg_arb_round_robin: combinational round-robin grant selection.
//   reqs_i   - request vector
//   ptr_i    - highest-priority index; search wraps from here
//   grants_o - one-hot grant (zero when no request)
//   id_o     - index of the granted requester (0 when none)
//   v_o      - a grant was issued
module bsg_arb_round_robin #(
   parameter int unsigned width_p    = 2,
   parameter int unsigned id_width_p = 1
) (
   input  logic [width_p-1:0]    reqs_i,
   input  logic [id_width_p-1:0] ptr_i,
   output logic [width_p-1:0]    grants_o,
   output logic [id_width_p-1:0] id_o,
   output logic                  v_o
);

   int unsigned idx;

   always_comb begin
      grants_o = '0;
      id_o     = '0;
      v_o      = 1'b0;
      idx      = 0;
      for (int unsigned i = 0; i < width_p; i++) begin
         idx = (32'(ptr_i) + i) % width_p;
         if (!v_o && reqs_i[idx[id_width_p-1:0]]) begin
            v_o                          = 1'b1;
            grants_o[idx[id_width_p-1:0]] = 1'b1;
            id_o                         = idx[id_width_p-1:0];
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port among num_req_p requesters
// (index 0 = back-end LSU) with round-robin grant, optional grant locking,
// a single pending read tag and flush squashing of requester 0.
//   clk_i   - clock, all state on rising edge
//   reset_i - synchronous active-high reset
//   bus     - dmem_arbiter_if.slave (requester handshake + memory port)
module dmem_arbiter
   import Purple_Jade_pkg::*;
#(
   parameter int unsigned num_req_p    = DMEM_NUM_REQ,
   parameter int unsigned addr_width_p = WORD_SIZE_P
) (
   input  logic          clk_i,
   input  logic          reset_i,
   dmem_arbiter_if.slave bus
);

   localparam int unsigned id_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

   dmem_arb_state_e      state_q, state_d;
   logic [id_w_lp-1:0]   owner_q, owner_d;
   logic [id_w_lp-1:0]   rr_ptr_q, rr_ptr_d;
   logic                 tag_v_q, tag_v_d;
   logic [id_w_lp-1:0]   tag_id_q, tag_id_d;

   logic [num_req_p-1:0] eff_v, owner_mask, arb_reqs, grants;
   logic [id_w_lp-1:0]   grant_id;
   logic                 grant_v;
   logic                 xfer_w, xfer_lock;
   logic [addr_width_p-1:0] xfer_addr;
   logic [num_req_p-1:0] resp_v;

   bsg_arb_round_robin #(
      .width_p    (num_req_p),
      .id_width_p (id_w_lp)
   ) rr_arb (
      .reqs_i   (arb_reqs),
      .ptr_i    (rr_ptr_q),
      .grants_o (grants),
      .id_o     (grant_id),
      .v_o      (grant_v)
   );

   // Request masking: flush hides requester 0, LOCKED restricts to the owner,
   // reset blocks every grant in the reset cycle itself.
   always_comb begin
      eff_v      = bus.req_v_i;
      eff_v[0]   = bus.req_v_i[0] & ~bus.flush_i;
      owner_mask = '0;
      owner_mask[owner_q] = 1'b1;
      arb_reqs   = eff_v;
      if (state_q == LOCKED) arb_reqs = eff_v & owner_mask;
      if (reset_i)           arb_reqs = '0;
   end

   // Memory command muxing; address/data forced to zero when not valid.
   always_comb begin
      xfer_w                = bus.req_w_i[grant_id];
      xfer_lock             = bus.req_lock_i[grant_id];
      xfer_addr             = bus.req_addr_i[grant_id];
      bus.req_ready_o       = grants;
      bus.data_mem_w_v_i    = 1'b0;
      bus.data_mem_w_addr_i = '0;
      bus.data_mem_w_data_i = '0;
      bus.data_mem_r_v_i    = 1'b0;
      bus.data_mem_r_addr_i = '0;
      if (grant_v) begin
         if (xfer_w) begin
            bus.data_mem_w_v_i    = 1'b1;
            bus.data_mem_w_addr_i = xfer_addr;
            bus.data_mem_w_data_i = bus.req_data_i[grant_id];
         end else begin
            bus.data_mem_r_v_i    = 1'b1;
            bus.data_mem_r_addr_i = xfer_addr;
         end
      end
   end

   // Next state: FSM, round-robin pointer, pending read tag.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      tag_v_d  = grant_v & ~xfer_w;
      tag_id_d = grant_id;
      case (state_q)
         ARB: begin
            if (grant_v) begin
               rr_ptr_d = (grant_id == id_w_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
               if (xfer_lock) begin
                  state_d = LOCKED;
                  owner_d = grant_id;
               end
            end
         end
         LOCKED: begin
            if (bus.flush_i && owner_q == '0) state_d = ARB;
            else if (grant_v && !xfer_lock)   state_d = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   // Response is combinational off the tag so a flush or reset in the
   // response cycle itself still squashes it.
   always_comb begin
      resp_v = '0;
      if (tag_v_q && !reset_i) resp_v[tag_id_q] = 1'b1;
      if (bus.flush_i)         resp_v[0] = 1'b0;
      bus.resp_v_o    = resp_v;
      bus.resp_data_o = (|resp_v) ? bus.data_mem_r_data_o : '0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ARB;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         tag_v_q  <= 1'b0;
         tag_id_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         tag_v_q  <= tag_v_d;
         tag_id_q <= tag_id_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// small registered memory model on the command port.
module tb_dmem_arbiter;
   import Purple_Jade_pkg::*;

   logic clk = 1'b0;
   logic reset_i;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   dmem_arbiter_if #(.num_req_p(2), .addr_width_p(32)) bus ();

   dmem_arbiter #(.num_req_p(2), .addr_width_p(32)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   // Memory: contents mem[i] = A000_0000 + i after reset, read data one cycle later.
   always @(posedge clk) begin
      if (reset_i) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
         bus.data_mem_r_data_o <= '0;
      end else begin
         if (bus.data_mem_w_v_i) mem[bus.data_mem_w_addr_i[7:0]] <= bus.data_mem_w_data_i;
         if (bus.data_mem_r_v_i) bus.data_mem_r_data_o <= mem[bus.data_mem_r_addr_i[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [1:0] v, input logic [1:0] w, input logic [1:0] lock,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
      bus.req_v_i       = v;
      bus.req_w_i       = w;
      bus.req_lock_i    = lock;
      bus.req_addr_i[0] = a0;
      bus.req_addr_i[1] = a1;
      bus.req_data_i[0] = d0;
      bus.req_data_i[1] = d1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_i     = 1'b1;
      bus.flush_i = 1'b0;
      set_req(2'b11, 2'b00, 2'b00, 32'h1, 32'h2, 32'h0, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("rst_ready",  32'(bus.req_ready_o), 32'h0);
      chk("rst_resp_v", 32'(bus.resp_v_o), 32'h0);
      chk("rst_w_v",    32'(bus.data_mem_w_v_i), 32'h0);
      chk("rst_r_v",    32'(bus.data_mem_r_v_i), 32'h0);
      chk("rst_rdata",  bus.resp_data_o, 32'h0);
      next_cycle();
      reset_i = 1'b0;

      // Both requesters read continuously: grants alternate 0,1,0,1
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_ready",  32'(bus.req_ready_o), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_r_v",    32'(bus.data_mem_r_v_i), 32'h1);
         chk("rr_r_addr", bus.data_mem_r_addr_i, (i % 2 == 0) ? 32'h1 : 32'h2);
         if (i > 0) begin
            chk("rr_resp_v", 32'(bus.resp_v_o), (i % 2 == 0) ? 32'h2 : 32'h1);
            chk("rr_rdata",  bus.resp_data_o, (i % 2 == 0) ? 32'hA000_0002 : 32'hA000_0001);
         end
         next_cycle();
      end
      set_req(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("rr_last_resp_v", 32'(bus.resp_v_o), 32'h2);
      chk("rr_last_rdata",  bus.resp_data_o, 32'hA000_0002);
      chk("idle_ready",     32'(bus.req_ready_o), 32'h0);
      chk("idle_r_v",       32'(bus.data_mem_r_v_i), 32'h0);
      chk("idle_w_v",       32'(bus.data_mem_w_v_i), 32'h0);
      chk("idle_r_addr",    bus.data_mem_r_addr_i, 32'h0);
      chk("idle_w_addr",    bus.data_mem_w_addr_i, 32'h0);
      chk("idle_w_data",    bus.data_mem_w_data_i, 32'h0);
      next_cycle();

      // Write BEEF to 0x40 by requester 1, then read it back by requester 0
      set_req(2'b10, 2'b10, 2'b00, 32'h0, 32'h40, 32'h0, 32'hBEEF);
      @(negedge clk);
      chk("wr_ready",  32'(bus.req_ready_o), 32'h2);
      chk("wr_w_v",    32'(bus.data_mem_w_v_i), 32'h1);
      chk("wr_w_addr", bus.data_mem_w_addr_i, 32'h40);
      chk("wr_w_data", bus.data_mem_w_data_i, 32'hBEEF);
      chk("wr_r_v",    32'(bus.data_mem_r_v_i), 32'h0);
      next_cycle();
      set_req(2'b01, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("rb_ready",  32'(bus.req_ready_o), 32'h1);
      chk("rb_r_addr", bus.data_mem_r_addr_i, 32'h40);
      chk("wr_no_resp", 32'(bus.resp_v_o), 32'h0);
      next_cycle();
      set_req(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("rb_resp_v", 32'(bus.resp_v_o), 32'h1);
      chk("rb_rdata",  bus.resp_data_o, 32'hBEEF);
      next_cycle();

      // Requester 1 locked write burst while requester 0 keeps requesting
      set_req(2'b11, 2'b10, 2'b10, 32'h20, 32'h10, 32'h0, 32'h1234);
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         chk("lock_ready", 32'(bus.req_ready_o), 32'h2);
         chk("lock_w_v",   32'(bus.data_mem_w_v_i), 32'h1);
         chk("lock_w_addr", bus.data_mem_w_addr_i, 32'h10);
         next_cycle();
      end
      bus.req_lock_i = 2'b00;
      @(negedge clk);
      chk("unlock_ready", 32'(bus.req_ready_o), 32'h2);
      chk("unlock_w_data", bus.data_mem_w_data_i, 32'h1234);
      next_cycle();

      // After the lock, rr_ptr=0: requester 0 reads 0x20, then flush
      set_req(2'b11, 2'b00, 2'b00, 32'h20, 32'h30, 32'h0, 32'h0);
      @(negedge clk);
      chk("post_lock_ready", 32'(bus.req_ready_o), 32'h1);
      chk("post_lock_r_addr", bus.data_mem_r_addr_i, 32'h20);
      next_cycle();
      bus.flush_i = 1'b1;
      @(negedge clk);
      chk("flush_ready",  32'(bus.req_ready_o), 32'h2);
      chk("flush_resp_v", 32'(bus.resp_v_o), 32'h0);
      chk("flush_r_addr", bus.data_mem_r_addr_i, 32'h30);
      next_cycle();
      bus.flush_i = 1'b0;
      set_req(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("flush_r1_resp_v", 32'(bus.resp_v_o), 32'h2);
      chk("flush_r1_rdata",  bus.resp_data_o, 32'hA000_0030);
      next_cycle();

      // Lock by requester 0 broken by a flush
      set_req(2'b01, 2'b00, 2'b01, 32'h05, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("lock0_ready", 32'(bus.req_ready_o), 32'h1);
      next_cycle();
      bus.flush_i = 1'b1;
      set_req(2'b11, 2'b00, 2'b00, 32'h05, 32'h06, 32'h0, 32'h0);
      @(negedge clk);
      chk("lock0_flush_ready",  32'(bus.req_ready_o), 32'h0);
      chk("lock0_flush_resp_v", 32'(bus.resp_v_o), 32'h0);
      chk("lock0_flush_r_v",    32'(bus.data_mem_r_v_i), 32'h0);
      next_cycle();
      bus.flush_i = 1'b0;
      @(negedge clk);
      chk("lock0_released_ready", 32'(bus.req_ready_o), 32'h2);
      chk("lock0_released_addr",  bus.data_mem_r_addr_i, 32'h06);
      chk("lock0_no_resp",        32'(bus.resp_v_o), 32'h0);
      next_cycle();
      set_req(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("lock0_r1_resp_v", 32'(bus.resp_v_o), 32'h2);
      chk("lock0_r1_rdata",  bus.resp_data_o, 32'hA000_0006);
      next_cycle();

      // Reset the cycle after a read grant
      set_req(2'b11, 2'b00, 2'b00, 32'h07, 32'h08, 32'h0, 32'h0);
      @(negedge clk);
      chk("pre_rst_ready", 32'(bus.req_ready_o), 32'h1);
      next_cycle();
      reset_i = 1'b1;
      @(negedge clk);
      chk("mid_rst_resp_v", 32'(bus.resp_v_o), 32'h0);
      chk("mid_rst_ready",  32'(bus.req_ready_o), 32'h0);
      chk("mid_rst_r_v",    32'(bus.data_mem_r_v_i), 32'h0);
      chk("mid_rst_w_v",    32'(bus.data_mem_w_v_i), 32'h0);
      chk("mid_rst_r_addr", bus.data_mem_r_addr_i, 32'h0);
      chk("mid_rst_rdata",  bus.resp_data_o, 32'h0);
      next_cycle();
      reset_i = 1'b0;
      @(negedge clk);
      chk("post_rst_ready",  32'(bus.req_ready_o), 32'h1);
      chk("post_rst_resp_v", 32'(bus.resp_v_o), 32'h0);
      chk("post_rst_r_addr", bus.data_mem_r_addr_i, 32'h07);
      next_cycle();
      set_req(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("post_rst_resp_v2", 32'(bus.resp_v_o), 32'h1);
      chk("post_rst_rdata",   bus.resp_data_o, 32'hA000_0007);
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2, meaning number of requesters sharing the data memory port (index 0 = back-end LSU).
REQ-002 SHALL have parameter addr_width_p, default WORD_SIZE_P, meaning the data memory address width.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 req_v_i  input  num_req_p  per-requester request valid.
REQ-006 req_w_i  input  num_req_p  per-requester op: 1 = write, 0 = read.
REQ-007 req_lock_i  input  num_req_p  per-requester request to hold the grant after this transfer.
REQ-008 req_addr_i  input  num_req_p x addr_width_p  per-requester address.
REQ-009 req_data_i  input  num_req_p x WORD_SIZE_P  per-requester write data.
REQ-010 req_ready_o  output  num_req_p  grant; a transfer occurs when req_v_i[k] and req_ready_o[k] are both high.
REQ-011 resp_v_o  output  num_req_p  read-data valid, one-hot.
REQ-012 resp_data_o  output  WORD_SIZE_P  shared read-data bus.
REQ-013 flush_i  input  1  back-end mispredict; squashes requester 0 activity.
REQ-014 data_mem_w_v_i, data_mem_w_addr_i, data_mem_w_data_i, data_mem_r_v_i, data_mem_r_addr_i  output  1/addr_width_p/WORD_SIZE_P/1/addr_width_p  memory command port.
REQ-015 data_mem_r_data_o  input  WORD_SIZE_P  memory read data, valid the cycle after data_mem_r_v_i.

Function
REQ-016 SHALL issue at most one memory operation per cycle; req_ready_o SHALL be one-hot or zero.
REQ-017 ARB state: grant SHALL go to the first valid requester at or after rr_ptr (wrapping); after a transfer by k, rr_ptr SHALL become (k+1) mod num_req_p.
REQ-018 LOCKED state: entered when the granted requester transfers with req_lock_i high; only the owner SHALL be granted; the state SHALL return to ARB after an owner transfer with req_lock_i low; rr_ptr SHALL NOT advance while LOCKED.
REQ-019 A write transfer SHALL drive data_mem_w_v_i=1 with the requester's address/data in the same cycle (combinational); writes SHALL produce no response.
REQ-020 A read transfer SHALL drive data_mem_r_v_i=1 in the same cycle and record owner id in a pending-tag register; the next cycle resp_v_o[owner]=1 with resp_data_o=data_mem_r_data_o.
REQ-021 Back-to-back reads from any requesters SHALL be sustained at one per cycle; there is no response backpressure.
REQ-022 flush_i high SHALL: deassert req_ready_o[0] that cycle; clear a pending tag owned by requester 0 so resp_v_o[0] stays 0 next cycle; return LOCKED-by-0 to ARB. Pending tags of other requesters SHALL be unaffected.
REQ-023 With no valid request, all memory valids SHALL be 0 and rr_ptr SHALL hold.
REQ-024 Memory address/data outputs SHALL be 0 when the matching valid is 0.

Reset
REQ-025 On reset_i: state=ARB, rr_ptr=0, pending tag invalid; req_ready_o, resp_v_o, data_mem_w_v_i, data_mem_r_v_i SHALL be 0 in the reset cycle; resp_data_o=0.
REQ-026 Reset mid-read SHALL suppress the response that would follow.

Structure
REQ-027 Purple_Jade_pkg SHALL hold the arbiter state enum (ARB, LOCKED) and DMEM_NUM_REQ constant; WORD_SIZE_P comes from it.
REQ-028 Grant selection SHALL use one sub-module, bsg_arb_round_robin; FSM, tag register and muxing stay in dmem_arbiter.

Verification
REQ-029 Both requesters read continuously from reset -> grants alternate 0,1,0,1; each resp_v_o asserted exactly one cycle after its grant with the matching data.
REQ-030 Requester 1 writes 0x1234 to 0x10 with lock high for 3 beats while requester 0 is valid -> requester 0 not granted until the lock-low beat completes; rr_ptr=0 afterwards.
REQ-031 Requester 0 reads 0x20, flush_i pulses the next cycle -> resp_v_o[0]=0; a simultaneous requester 1 read response is delivered.
REQ-032 reset_i asserted the cycle after a read grant -> no resp_v_o; all outputs 0; first post-reset grant goes to requester 0.
REQ-033 Write 0xBEEF to 0x40 by requester 1, then read 0x40 by requester 0 -> resp_data_o=0xBEEF one cycle after the read grant.
